// File: rtl/interrupt_acknowledge_sequencer.sv
// 8259A acknowledge control-state engine: follows INTA pulses and poll reads. ACK_SEQUENCE_TIMEOUT_EN adds an abort timer.
// Latency: the state and the strobes are registered one clock after the qualifying edge is sampled.
// Backpressure: none. Every event is a one-cycle strobe, consumed in the cycle it is sampled.
module interrupt_acknowledge_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       interrupt_acknowledge_n,
    input  logic       u8086_or_mcs80_config,
    input  logic       write_initial_command_word_1,
    input  logic       poll_command,
    input  logic       read,
    input  logic [7:0] highest_level_in_request,
    output logic [2:0] control_state,
    output logic [7:0] interrupt_when_ack1,
    output logic       latch_in_service,
    output logic       end_of_acknowledge_sequence,
    output logic       end_of_poll_command,
    output logic       ack_timeout
);

    typedef enum logic [2:0] {
        READY = 3'b000,
        ACK1  = 3'b001,
        ACK2  = 3'b010,
        ACK3  = 3'b011,
        POLL  = 3'b100
    } state_t;

    if ((64'd1 << TIMEOUT_WIDTH) <= 64'(TIMEOUT_CYCLES)) begin : g_width_check
        $error("TIMEOUT_WIDTH too narrow for TIMEOUT_CYCLES");
    end

    state_t state;
    logic   prev_inta;
    logic   prev_read;
    logic   nedge;
    logic   pedge;
    logic   read_fall;
    logic   in_ack;
    logic   timeout_hit;

    assign nedge     = prev_inta & ~interrupt_acknowledge_n;
    assign pedge     = ~prev_inta & interrupt_acknowledge_n;
    assign read_fall = prev_read & ~read;
    assign in_ack    = (state == ACK1) || (state == ACK2) || (state == ACK3);

    assign control_state = state;

`ifdef ACK_SEQUENCE_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] timeout_cnt;

    // Any INTA edge restarts the wait, and it also outranks a timeout that lands in the same cycle.
    assign timeout_hit = in_ack && !nedge && !pedge && (timeout_cnt == TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            timeout_cnt <= '0;
        end else if (!in_ack || nedge || pedge || write_initial_command_word_1) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                       <= READY;
            prev_inta                   <= 1'b1;
            prev_read                   <= 1'b0;
            interrupt_when_ack1         <= 8'h00;
            latch_in_service            <= 1'b0;
            end_of_acknowledge_sequence <= 1'b0;
            end_of_poll_command         <= 1'b0;
            ack_timeout                 <= 1'b0;
        end else begin
            prev_inta                   <= interrupt_acknowledge_n;
            prev_read                   <= read;
            latch_in_service            <= 1'b0;
            end_of_acknowledge_sequence <= 1'b0;
            end_of_poll_command         <= 1'b0;
            ack_timeout                 <= 1'b0;

            if (write_initial_command_word_1) begin
                state               <= READY;
                interrupt_when_ack1 <= 8'h00;
            end else if (timeout_hit) begin
                state               <= READY;
                interrupt_when_ack1 <= 8'h00;
                ack_timeout         <= 1'b1;
            end else begin
                case (state)
                    READY: begin
                        // An INTA falling edge outranks a poll request in the same cycle.
                        if (nedge) begin
                            state               <= ACK1;
                            interrupt_when_ack1 <= highest_level_in_request;
                            latch_in_service    <= 1'b1;
                        end else if (poll_command) begin
                            state <= POLL;
                        end
                    end
                    ACK1: begin
                        if (nedge) begin
                            state <= ACK2;
                        end
                    end
                    ACK2: begin
                        if (u8086_or_mcs80_config) begin
                            if (pedge) begin
                                state                       <= READY;
                                interrupt_when_ack1         <= 8'h00;
                                end_of_acknowledge_sequence <= 1'b1;
                            end
                        end else if (nedge) begin
                            state <= ACK3;
                        end
                    end
                    ACK3: begin
                        if (pedge) begin
                            state                       <= READY;
                            interrupt_when_ack1         <= 8'h00;
                            end_of_acknowledge_sequence <= 1'b1;
                        end
                    end
                    POLL: begin
                        // The polled level is marked in service once the read that returned it completes.
                        if (read_fall) begin
                            state               <= READY;
                            interrupt_when_ack1 <= 8'h00;
                            end_of_poll_command <= 1'b1;
                            latch_in_service    <= 1'b1;
                        end
                    end
                    default: begin
                        state               <= READY;
                        interrupt_when_ack1 <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Directed bench for interrupt_acknowledge_sequencer: ACK sequences in both modes, poll, aborts and timeout.
module tb_interrupt_acknowledge_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       interrupt_acknowledge_n = 1'b1;
    logic       u8086_or_mcs80_config = 1'b1;
    logic       write_initial_command_word_1 = 1'b0;
    logic       poll_command = 1'b0;
    logic       read = 1'b0;
    logic [7:0] highest_level_in_request = 8'h00;
    logic [2:0] control_state;
    logic [7:0] interrupt_when_ack1;
    logic       latch_in_service;
    logic       end_of_acknowledge_sequence;
    logic       end_of_poll_command;
    logic       ack_timeout;

    int checks = 0;
    int failures = 0;
    int lis_cnt = 0;
    int eoa_cnt = 0;
    int eop_cnt = 0;
    int tmo_cnt = 0;

    interrupt_acknowledge_sequencer #(.TIMEOUT_CYCLES(10), .TIMEOUT_WIDTH(8)) dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .interrupt_acknowledge_n      (interrupt_acknowledge_n),
        .u8086_or_mcs80_config        (u8086_or_mcs80_config),
        .write_initial_command_word_1 (write_initial_command_word_1),
        .poll_command                 (poll_command),
        .read                         (read),
        .highest_level_in_request     (highest_level_in_request),
        .control_state                (control_state),
        .interrupt_when_ack1          (interrupt_when_ack1),
        .latch_in_service             (latch_in_service),
        .end_of_acknowledge_sequence  (end_of_acknowledge_sequence),
        .end_of_poll_command          (end_of_poll_command),
        .ack_timeout                  (ack_timeout)
    );

    always #5 clock = ~clock;

    // Drive INTA, advance one clock, sample 1 ns after the edge and tally the strobes.
    task automatic cyc(input logic inta_val);
        interrupt_acknowledge_n = inta_val;
        @(posedge clock);
        #1;
        lis_cnt += int'(latch_in_service);
        eoa_cnt += int'(end_of_acknowledge_sequence);
        eop_cnt += int'(end_of_poll_command);
        tmo_cnt += int'(ack_timeout);
    endtask

    task automatic pulse(input int n_low, input int n_high);
        for (int i = 0; i < n_low; i++) cyc(1'b0);
        for (int i = 0; i < n_high; i++) cyc(1'b1);
    endtask

    task automatic clear_counts();
        lis_cnt = 0; eoa_cnt = 0; eop_cnt = 0; tmo_cnt = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        checks++;
        if (control_state !== 3'b000 || interrupt_when_ack1 !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: state=%b iwa=%h, required state=000 iwa=00", control_state, interrupt_when_ack1);
        end
        checks++;
        if ({latch_in_service, end_of_acknowledge_sequence, end_of_poll_command, ack_timeout} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes: lis/eoa/eop/tmo=%b%b%b%b, required 0000", latch_in_service,
                     end_of_acknowledge_sequence, end_of_poll_command, ack_timeout);
        end
        reset_n = 1'b1;
        cyc(1'b1);
    endtask

    task automatic test_8086_sequence();
        u8086_or_mcs80_config = 1'b1;
        highest_level_in_request = 8'h04;
        clear_counts();
        cyc(1'b0);
        checks++;
        if (control_state !== 3'b001 || latch_in_service !== 1'b1 || interrupt_when_ack1 !== 8'h04) begin
            failures++;
            $display("FAIL ack1_entry: state=%b lis=%b iwa=%h, required 001 1 04", control_state, latch_in_service, interrupt_when_ack1);
        end
        highest_level_in_request = 8'h20;
        cyc(1'b0);
        cyc(1'b0);
        pulse(0, 3);
        checks++;
        if (control_state !== 3'b001) begin
            failures++;
            $display("FAIL ack1_hold_on_pedge: state=%b, required 001", control_state);
        end
        pulse(3, 0);
        checks++;
        if (control_state !== 3'b010 || interrupt_when_ack1 !== 8'h04) begin
            failures++;
            $display("FAIL ack2_8086: state=%b iwa=%h, required 010 04", control_state, interrupt_when_ack1);
        end
        cyc(1'b1);
        checks++;
        if (control_state !== 3'b000 || end_of_acknowledge_sequence !== 1'b1 || interrupt_when_ack1 !== 8'h00) begin
            failures++;
            $display("FAIL end_8086: state=%b eoa=%b iwa=%h, required 000 1 00", control_state,
                     end_of_acknowledge_sequence, interrupt_when_ack1);
        end
        cyc(1'b1);
        cyc(1'b1);
        checks++;
        if (lis_cnt !== 1 || eoa_cnt !== 1) begin
            failures++;
            $display("FAIL pulse_counts_8086: lis=%0d eoa=%0d, required 1 1", lis_cnt, eoa_cnt);
        end
    endtask

    task automatic test_mcs80_sequence();
        u8086_or_mcs80_config = 1'b0;
        highest_level_in_request = 8'h80;
        clear_counts();
        pulse(2, 2);
        checks++;
        if (control_state !== 3'b001 || interrupt_when_ack1 !== 8'h80) begin
            failures++;
            $display("FAIL mcs80_ack1: state=%b iwa=%h, required 001 80", control_state, interrupt_when_ack1);
        end
        pulse(2, 2);
        checks++;
        if (control_state !== 3'b010) begin
            failures++;
            $display("FAIL mcs80_ack2_hold_on_pedge: state=%b, required 010", control_state);
        end
        pulse(2, 0);
        checks++;
        if (control_state !== 3'b011 || interrupt_when_ack1 !== 8'h80 || eoa_cnt !== 0) begin
            failures++;
            $display("FAIL mcs80_ack3: state=%b iwa=%h eoa=%0d, required 011 80 0", control_state, interrupt_when_ack1, eoa_cnt);
        end
        cyc(1'b1);
        checks++;
        if (control_state !== 3'b000 || end_of_acknowledge_sequence !== 1'b1 || interrupt_when_ack1 !== 8'h00) begin
            failures++;
            $display("FAIL mcs80_end: state=%b eoa=%b iwa=%h, required 000 1 00", control_state,
                     end_of_acknowledge_sequence, interrupt_when_ack1);
        end
        pulse(0, 2);
        checks++;
        if (eoa_cnt !== 1 || lis_cnt !== 1) begin
            failures++;
            $display("FAIL mcs80_counts: eoa=%0d lis=%0d, required 1 1", eoa_cnt, lis_cnt);
        end
        u8086_or_mcs80_config = 1'b1;
    endtask

    task automatic test_poll();
        clear_counts();
        poll_command = 1'b1;
        cyc(1'b1);
        poll_command = 1'b0;
        checks++;
        if (control_state !== 3'b100 || latch_in_service !== 1'b0) begin
            failures++;
            $display("FAIL poll_entry: state=%b lis=%b, required 100 0", control_state, latch_in_service);
        end
        read = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        pulse(2, 2);
        checks++;
        if (control_state !== 3'b100 || lis_cnt !== 0) begin
            failures++;
            $display("FAIL poll_ignores_inta: state=%b lis=%0d, required 100 0", control_state, lis_cnt);
        end
        read = 1'b0;
        cyc(1'b1);
        checks++;
        if (control_state !== 3'b000 || end_of_poll_command !== 1'b1 || latch_in_service !== 1'b1) begin
            failures++;
            $display("FAIL poll_end: state=%b eop=%b lis=%b, required 000 1 1", control_state,
                     end_of_poll_command, latch_in_service);
        end
        cyc(1'b1);
        checks++;
        if (end_of_poll_command !== 1'b0 || eop_cnt !== 1 || eoa_cnt !== 0) begin
            failures++;
            $display("FAIL poll_single_strobe: eop=%b eop_cnt=%0d eoa_cnt=%0d, required 0 1 0",
                     end_of_poll_command, eop_cnt, eoa_cnt);
        end
    endtask

    task automatic test_poll_vs_inta();
        highest_level_in_request = 8'h02;
        clear_counts();
        poll_command = 1'b1;
        cyc(1'b0);
        poll_command = 1'b0;
        checks++;
        if (control_state !== 3'b001 || latch_in_service !== 1'b1 || interrupt_when_ack1 !== 8'h02) begin
            failures++;
            $display("FAIL poll_vs_inta: state=%b lis=%b iwa=%h, required 001 1 02", control_state,
                     latch_in_service, interrupt_when_ack1);
        end
        pulse(0, 2);
        pulse(2, 2);
        checks++;
        if (control_state !== 3'b000 || eoa_cnt !== 1 || eop_cnt !== 0) begin
            failures++;
            $display("FAIL poll_discarded: state=%b eoa=%0d eop=%0d, required 000 1 0", control_state, eoa_cnt, eop_cnt);
        end
    endtask

    task automatic test_aborts();
        highest_level_in_request = 8'h10;
        clear_counts();
        pulse(1, 1);
        cyc(1'b0);
        checks++;
        if (control_state !== 3'b010) begin
            failures++;
            $display("FAIL abort_setup_ack2: state=%b, required 010", control_state);
        end
        // The rising edge here would end the sequence if ICW1 did not take priority.
        write_initial_command_word_1 = 1'b1;
        cyc(1'b1);
        write_initial_command_word_1 = 1'b0;
        checks++;
        if (control_state !== 3'b000 || interrupt_when_ack1 !== 8'h00 || end_of_acknowledge_sequence !== 1'b0
            || latch_in_service !== 1'b0) begin
            failures++;
            $display("FAIL icw1_abort: state=%b iwa=%h eoa=%b lis=%b, required 000 00 0 0", control_state,
                     interrupt_when_ack1, end_of_acknowledge_sequence, latch_in_service);
        end
        cyc(1'b1);
        checks++;
        if (eoa_cnt !== 0 || lis_cnt !== 1) begin
            failures++;
            $display("FAIL icw1_no_strobes: eoa=%0d lis=%0d, required 0 1", eoa_cnt, lis_cnt);
        end
        highest_level_in_request = 8'h40;
        pulse(2, 0);
        reset_n = 1'b0;
        cyc(1'b1);
        checks++;
        if (control_state !== 3'b000 || interrupt_when_ack1 !== 8'h00 || latch_in_service !== 1'b0
            || end_of_acknowledge_sequence !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_ack1: state=%b iwa=%h lis=%b eoa=%b, required 000 00 0 0", control_state,
                     interrupt_when_ack1, latch_in_service, end_of_acknowledge_sequence);
        end
        reset_n = 1'b1;
        cyc(1'b1);
        cyc(1'b0);
        checks++;
        if (control_state !== 3'b001 || interrupt_when_ack1 !== 8'h40) begin
            failures++;
            $display("FAIL restart_after_reset: state=%b iwa=%h, required 001 40", control_state, interrupt_when_ack1);
        end
        pulse(0, 1);
        pulse(1, 1);
        checks++;
        if (control_state !== 3'b000) begin
            failures++;
            $display("FAIL restart_complete: state=%b, required 000", control_state);
        end
    endtask

    task automatic test_timeout();
        highest_level_in_request = 8'h08;
        clear_counts();
        cyc(1'b0);
        // The rising edge restarts the wait, so the abort comes 10 quiet cycles after it.
        cyc(1'b1);
        for (int i = 0; i < 9; i++) cyc(1'b1);
        checks++;
        if (control_state !== 3'b001 || tmo_cnt !== 0) begin
            failures++;
            $display("FAIL timeout_not_early: state=%b tmo=%0d, required 001 0", control_state, tmo_cnt);
        end
        cyc(1'b1);
`ifdef ACK_SEQUENCE_TIMEOUT_EN
        checks++;
        if (control_state !== 3'b000 || ack_timeout !== 1'b1 || interrupt_when_ack1 !== 8'h00
            || end_of_acknowledge_sequence !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort: state=%b tmo=%b iwa=%h eoa=%b, required 000 1 00 0", control_state,
                     ack_timeout, interrupt_when_ack1, end_of_acknowledge_sequence);
        end
        cyc(1'b1);
        checks++;
        if (ack_timeout !== 1'b0 || tmo_cnt !== 1 || eoa_cnt !== 0) begin
            failures++;
            $display("FAIL timeout_single: tmo=%b tmo_cnt=%0d eoa=%0d, required 0 1 0", ack_timeout, tmo_cnt, eoa_cnt);
        end
`else
        for (int i = 0; i < 20; i++) cyc(1'b1);
        checks++;
        if (control_state !== 3'b001 || tmo_cnt !== 0 || interrupt_when_ack1 !== 8'h08) begin
            failures++;
            $display("FAIL no_timeout: state=%b tmo=%0d iwa=%h, required 001 0 08", control_state, tmo_cnt, interrupt_when_ack1);
        end
        write_initial_command_word_1 = 1'b1;
        cyc(1'b1);
        write_initial_command_word_1 = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_8086_sequence();
        test_mcs80_sequence();
        test_poll();
        test_poll_vs_inta();
        test_aborts();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
